// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage pipeline. Holds the fetch PC, presents
// it to instruction memory (zero-latency, combinational read) and registers the
// returned word into the single-entry IF/ID boundary. Also keeps saturating
// counts of cycles in which a stall or a flush was actually applied.
//
// Ports:
//   clk_i            system clock, rising-edge
//   rst_i            asynchronous active-high reset
//   start_i          run enable; low freezes PC and feeds bubbles
//   stall_i          load-use stall request (wins over flush_i)
//   flush_i          branch taken in ID: redirect PC, squash IF/ID
//   branch_target_i  redirect address, bits [1:0] forced to zero
//   imem_instr_i     instruction word for imem_addr_o, same cycle
//   imem_addr_o      instruction-memory byte address (= pc_o)
//   pc_o             current fetch PC
//   ifid_pc_o        PC of the instruction in IF/ID
//   ifid_instr_o     instruction in IF/ID
//   ifid_valid_o     IF/ID holds a real instruction (not a bubble)
//   stall_cnt_o      cycles in which a stall was applied (saturating)
//   flush_cnt_o      cycles in which a flush was applied (saturating)
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  input  logic [31:0]      imem_instr_i,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-cycle action, decoded in priority order idle > stall > flush > run.
  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_STALL = 2'd1,
    M_FLUSH = 2'd2,
    M_RUN   = 2'd3
  } mode_t;

  mode_t       mode;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] target_aligned;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Masking keeps every target bit "used" while word-aligning the redirect.
  assign target_aligned = branch_target_i & 32'hFFFF_FFFC;

  always_comb begin
    mode = M_RUN;
    if (!start_i)      mode = M_IDLE;
    else if (stall_i)  mode = M_STALL;
    else if (flush_i)  mode = M_FLUSH;
  end

  always_comb begin
    pc_d = pc_q;
    case (mode)
      M_FLUSH: pc_d = target_aligned;
      M_RUN:   pc_d = pc_q + 32'd4;   // wraps modulo 2^32
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID boundary: a stall freezes it; every other non-run cycle loads a bubble
  // that still carries the current PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      case (mode)
        M_STALL: begin
          ifid_pc_q    <= ifid_pc_q;
          ifid_instr_q <= ifid_instr_q;
          ifid_valid_q <= ifid_valid_q;
        end
        M_RUN: begin
          ifid_pc_q    <= pc_q;
          ifid_instr_q <= imem_instr_i;
          ifid_valid_q <= 1'b1;
        end
        default: begin
          ifid_pc_q    <= pc_q;
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Event counters: a flush masked by a stall is not counted, since the branch
  // is re-presented by decode once the stall clears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mode == M_STALL && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (mode == M_FLUSH && flush_cnt_q != CNT_MAX)
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. Two instances share all inputs: one with
// the default 32-bit counters, one with CNT_W=4 to reach counter saturation.
// Each clocked step pushes the expected post-edge state (from a small model of
// the fetch stage) into a queue, which is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] btgt;
  logic [31:0] imem_instr, imem_instr_n;
  logic [31:0] imem_addr, imem_addr_n;
  logic [31:0] pc, pc_n;
  logic [31:0] ifid_pc, ifid_pc_n;
  logic [31:0] ifid_instr, ifid_instr_n;
  logic        ifid_valid, ifid_valid_n;
  logic [31:0] scnt, fcnt;
  logic [3:0]  scnt_n, fcnt_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction memory contents: distinct per address, never equal to NOP.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5C;
  endfunction

  assign imem_instr   = word(imem_addr);
  assign imem_instr_n = word(imem_addr_n);

  if_stage dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(btgt), .imem_instr_i(imem_instr), .imem_addr_o(imem_addr),
    .pc_o(pc), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
    .ifid_valid_o(ifid_valid), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  if_stage #(.CNT_W(4)) dut_n (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(btgt), .imem_instr_i(imem_instr_n), .imem_addr_o(imem_addr_n),
    .pc_o(pc_n), .ifid_pc_o(ifid_pc_n), .ifid_instr_o(ifid_instr_n),
    .ifid_valid_o(ifid_valid_n), .stall_cnt_o(scnt_n), .flush_cnt_o(fcnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        v;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [3:0]  scn;
    logic [3:0]  fcn;
  } exp_t;

  exp_t sb[$];

  // Model state
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  logic        m_v;
  longint      m_sc, m_fc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic logic [3:0] sat4(input longint v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_ifpc = 32'd0; m_ifinstr = NOP; m_v = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".pc"},     pc,           e.pc);
    chk({tag, ".addr"},   imem_addr,    e.pc);
    chk({tag, ".ifpc"},   ifid_pc,      e.ifpc);
    chk({tag, ".instr"},  ifid_instr,   e.ifinstr);
    chk({tag, ".valid"},  ifid_valid,   e.v);
    chk({tag, ".scnt"},   scnt,         e.sc);
    chk({tag, ".fcnt"},   fcnt,         e.fc);
    chk({tag, ".pc_n"},   pc_n,         e.pc);
    chk({tag, ".scnt_n"}, scnt_n,       e.scn);
    chk({tag, ".fcnt_n"}, fcnt_n,       e.fcn);
  endtask

  // Called just after a falling edge; leaves just after the next falling edge.
  task automatic step(input string tag, input logic s, input logic st,
                      input logic fl, input logic [31:0] bt);
    exp_t e;
    start = s; stall = st; flush = fl; btgt = bt;
    if (!s) begin
      m_ifpc = m_pc; m_ifinstr = NOP; m_v = 1'b0;
    end else if (st) begin
      m_sc++;
    end else if (fl) begin
      m_ifpc = m_pc; m_ifinstr = NOP; m_v = 1'b0;
      m_pc = {bt[31:2], 2'b00};
      m_fc++;
    end else begin
      m_ifpc = m_pc; m_ifinstr = word(m_pc); m_v = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.ifpc = m_ifpc; e.ifinstr = m_ifinstr; e.v = m_v;
    e.sc = sat32(m_sc); e.fc = sat32(m_fc); e.scn = sat4(m_sc); e.fcn = sat4(m_fc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must change with no clock edge.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".pc"},    pc,         32'd0);
    chk({tag, ".ifpc"},  ifid_pc,    32'd0);
    chk({tag, ".instr"}, ifid_instr, NOP);
    chk({tag, ".valid"}, ifid_valid, 1'b0);
    chk({tag, ".scnt"},  scnt,       32'd0);
    chk({tag, ".fcnt"},  fcnt,       32'd0);
    chk({tag, ".scnt_n"}, scnt_n,    4'd0);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; btgt = 32'd0;
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("por.pc",    pc,         32'd0);
    chk("por.instr", ifid_instr, NOP);
    chk("por.valid", ifid_valid, 1'b0);
    chk("por.scnt",  scnt,       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset/run: 4 hazard-free cycles
    for (int i = 0; i < 4; i++) step("run", 1, 0, 0, 0);
    chk("tp_run.pc",    pc,         32'd16);
    chk("tp_run.ifpc",  ifid_pc,    32'd12);
    chk("tp_run.instr", ifid_instr, word(32'd12));
    chk("tp_run.valid", ifid_valid, 1'b1);

    // One stall, then reset while stall is still held
    step("pre_rst_stall", 1, 1, 0, 0);
    chk("tp_pre_rst.scnt", scnt, 32'd1);
    stall = 1'b1;
    mid_reset("rst_stall");

    // Stall at pc=8 for 2 cycles
    step("run2", 1, 0, 0, 0);
    step("run2", 1, 0, 0, 0);
    step("stall", 1, 1, 0, 0);
    step("stall", 1, 1, 0, 0);
    chk("tp_stall.pc",    pc,         32'd8);
    chk("tp_stall.ifpc",  ifid_pc,    32'd4);
    chk("tp_stall.instr", ifid_instr, word(32'd4));
    chk("tp_stall.scnt",  scnt,       32'd2);
    step("release", 1, 0, 0, 0);
    chk("tp_rel.pc",    pc,         32'd12);
    chk("tp_rel.ifpc",  ifid_pc,    32'd8);
    chk("tp_rel.instr", ifid_instr, word(32'd8));

    // Flush at pc=12
    step("flush", 1, 0, 1, 32'h40);
    chk("tp_flush.pc",    pc,         32'h40);
    chk("tp_flush.instr", ifid_instr, 32'h13);
    chk("tp_flush.valid", ifid_valid, 1'b0);
    chk("tp_flush.fcnt",  fcnt,       32'd1);

    // Simultaneous stall+flush at pc=20
    step("to20", 1, 0, 1, 32'h14);
    step("stall_flush", 1, 1, 1, 32'h80);
    chk("tp_sf.pc",   pc,   32'd20);
    chk("tp_sf.scnt", scnt, 32'd3);
    chk("tp_sf.fcnt", fcnt, 32'd2);
    step("flush_unaligned", 1, 0, 1, 32'h23);
    chk("tp_fu.pc", pc, 32'h20);

    // Idle at pc=24, hazards ignored
    step("to24", 1, 0, 1, 32'h18);
    step("idle", 0, 0, 0, 0);
    step("idle", 0, 1, 0, 0);
    step("idle", 0, 1, 1, 32'h100);
    step("idle", 0, 0, 1, 32'h200);
    chk("tp_idle.pc",    pc,         32'd24);
    chk("tp_idle.valid", ifid_valid, 1'b0);
    chk("tp_idle.fcnt",  fcnt,       32'd4);

    // PC wrap
    step("to_top", 1, 0, 1, 32'hFFFF_FFFC);
    step("wrap", 1, 0, 0, 0);
    chk("tp_wrap.pc",   pc,      32'd0);
    chk("tp_wrap.ifpc", ifid_pc, 32'hFFFF_FFFC);

    // Saturate the 4-bit stall counter
    for (int i = 0; i < 18; i++) step("sat", 1, 1, 0, 0);
    chk("tp_sat.scnt_n", scnt_n, 4'd15);
    chk("tp_sat.scnt",   scnt,   32'd21);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
